// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table (index = hex value) and defaults
// used by both the scan decoder and the forward encoder.
package seg7_pkg;

   localparam int SEG7_STABLE_DEFAULT = 4;

   // Active-high {g,f,e,d,c,b,a} glyph for each hex value 0..F.
   localparam logic [6:0] SEG7_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg7_encode(input logic [3:0] value);
      return SEG7_TABLE[value];
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph-to-hex lookup; unknown glyphs decode to 0 with err set.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] p,
   output logic [3:0] value,
   output logic       err
);

   always_comb begin
      value = '0;
      err   = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (p == SEG7_TABLE[i]) begin
            value = 4'(i);
            err   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex frame from a multiplexed active-low 7-seg bus,
// debouncing each digit and presenting completed frames on a valid/ready port.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = SEG7_STABLE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic [3:0]  out_err,
   output logic        overrun
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   logic [6:0]       p;
   logic [1:0]       sel;
   logic             sample_ok;
   logic [6:0]       prev_p;
   logic [1:0]       prev_sel;
   logic             prev_ok;
   logic [7:0]       cnt, cnt_next;
   logic             same, accept;
   logic [3:0]       dec_value;
   logic             dec_err;
   logic [3:0][3:0]  cap;
   logic [3:0]       cap_err;
   logic [3:0]       seen;
   logic             complete, load, handshake;

   assign p = ~seg;

   always_comb begin
      sel = '0;
      for (int i = 0; i < 4; i++) begin
         if (!an[i]) sel = 2'(i);
      end
      sample_ok = ($countones(~an) == 1);
   end

   // prev_ok is low after reset, so the first sample always restarts the count.
   assign same   = sample_ok && prev_ok && (p == prev_p) && (sel == prev_sel);
   assign accept = same && (cnt == CNT_MAX - 8'd1);

   always_comb begin
      if (!same)                cnt_next = '0;
      else if (cnt == CNT_MAX)  cnt_next = CNT_MAX;
      else                      cnt_next = cnt + 8'd1;
   end

   seg7_pattern_decode u_dec (
      .p     (p),
      .value (dec_value),
      .err   (dec_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_p   <= '0;
         prev_sel <= '0;
         prev_ok  <= 1'b0;
         cnt      <= '0;
         cap      <= '0;
         cap_err  <= '0;
      end else begin
         prev_p   <= p;
         prev_sel <= sel;
         prev_ok  <= sample_ok;
         cnt      <= cnt_next;
         if (accept) begin
            cap[sel]     <= dec_value;
            cap_err[sel] <= dec_err;
         end
      end
   end

   assign complete  = (seen == 4'hF);
   assign handshake = out_valid && out_ready;
   assign load      = complete && (!out_valid || out_ready);

   // A frame completing while the held one is still unconsumed is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= '0;
         overrun   <= 1'b0;
      end else begin
         seen <= (complete ? 4'h0 : seen) | (accept ? (4'b0001 << sel) : 4'h0);
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= cap;
            out_err   <= cap_err;
         end else if (complete) begin
            overrun   <= 1'b1;
         end else if (handshake) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
